// File: rtl/score_pkg.sv
// Shared encodings and the saturating BCD adder for the score keeper.
package score_pkg;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_PLAYING   = 2'b01;
  localparam logic [1:0] ST_WAIT_GEN  = 2'b10;
  localparam logic [1:0] ST_GAME_OVER = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } run_state_t;

  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // Ripple a decimal carry through four digits; a carry out of the top digit pins the score at 9999.
  function automatic logic [15:0] bcd_sat_add(input logic [15:0] a, input logic [3:0] inc);
    logic [15:0] sum;
    logic [4:0]  digit;
    logic [3:0]  carry;
    sum   = '0;
    carry = inc;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, a[i*4 +: 4]} + {1'b0, carry};
      if (digit > 5'd9) begin
        sum[i*4 +: 4] = 4'(digit - 5'd10);
        carry         = 4'd1;
      end else begin
        sum[i*4 +: 4] = digit[3:0];
        carry         = 4'd0;
      end
    end
    return (carry != 4'd0) ? SCORE_MAX : sum;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low {dp,g,f,e,d,c,b,a}; combinational, codes 10-15 blank.
module seg7_decoder
  import score_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 8'hC0;
      4'd1:    o_seg = 8'hF9;
      4'd2:    o_seg = 8'hA4;
      4'd3:    o_seg = 8'hB0;
      4'd4:    o_seg = 8'h99;
      4'd5:    o_seg = 8'h92;
      4'd6:    o_seg = 8'h82;
      4'd7:    o_seg = 8'hF8;
      4'd8:    o_seg = 8'h80;
      4'd9:    o_seg = 8'h90;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_keeper.sv
// Survival/high score keeper driving a 4-digit multiplexed 7-seg; score moves on the edge an event is seen, no backpressure.
// GAMEOVER_BLINK_EN: when defined, the display blinks with a BLINK_DIV half-period while in GAME_OVER.
module score_display_keeper #(
  parameter int SEC_DIV      = 25_000_000,
  parameter int SCAN_DIV     = 25_000,
  parameter int DODGE_POINTS = 1,
  parameter int BLINK_DIV    = 6_250_000
) (
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic [1:0]  current_state,
  input  logic        GEN_X,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic        new_record,
  output logic [7:0]  seg,
  output logic [3:0]  an
);
  import score_pkg::*;

  localparam int SEC_W  = $clog2(SEC_DIV + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam logic [3:0] DODGE_INC = 4'(DODGE_POINTS);

  if (DODGE_POINTS < 1 || DODGE_POINTS > 8 || SEC_DIV < 1 || SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("score_display_keeper: illegal parameter value");
  end

  run_state_t        r_state, w_state_nxt;
  logic [1:0]        r_prev_state;
  logic              r_gen_x_d;
  logic [SEC_W-1:0]  r_sec_cnt;
  logic [15:0]       r_score, r_high;
  logic              r_new_record;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit_idx;
  logic [3:0]        r_an;
  logic [7:0]        r_seg;

  logic        w_run_entry, w_go_entry, w_sec_tick, w_dodge, w_scan_wrap;
  logic [3:0]  w_inc, w_digit;
  logic [15:0] w_show;
  logic [7:0]  w_seg_dec;

  always_ff @(posedge clk_25MHz) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (current_state)
      ST_IDLE:                 w_state_nxt = S_IDLE;
      ST_PLAYING, ST_WAIT_GEN: w_state_nxt = S_RUN;
      ST_GAME_OVER:            w_state_nxt = S_HOLD;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run_entry = (r_prev_state == ST_IDLE) && (current_state == ST_PLAYING);
  assign w_go_entry  = (r_prev_state != ST_GAME_OVER) && (current_state == ST_GAME_OVER);
  assign w_sec_tick  = (w_state_nxt == S_RUN) && (r_sec_cnt == SEC_W'(SEC_DIV - 1));
  assign w_dodge     = (w_state_nxt == S_RUN) && GEN_X && !r_gen_x_d;
  assign w_inc       = {3'b000, w_sec_tick} + (w_dodge ? DODGE_INC : 4'd0);

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_prev_state <= ST_IDLE;
      r_gen_x_d    <= 1'b0;
      r_sec_cnt    <= '0;
      r_score      <= '0;
      r_high       <= '0;
      r_new_record <= 1'b0;
    end else begin
      r_prev_state <= current_state;
      r_gen_x_d    <= GEN_X;
      r_new_record <= 1'b0;
      if (w_state_nxt == S_RUN) begin
        if (w_run_entry) begin
          r_score   <= '0;
          r_sec_cnt <= '0;
        end else begin
          r_sec_cnt <= w_sec_tick ? '0 : r_sec_cnt + SEC_W'(1);
          if (w_inc != 4'd0) r_score <= bcd_sat_add(r_score, w_inc);
        end
      end
      // BCD digits order the same as binary, so a plain compare decides a new record.
      if (w_go_entry && (r_score > r_high)) begin
        r_high       <= r_score;
        r_new_record <= 1'b1;
      end
    end
  end

  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_show      = (r_state == S_IDLE) ? r_high : r_score;
  assign w_digit     = w_show[{r_digit_idx, 2'b00} +: 4];

  seg7_decoder u_seg7_decoder (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  // The digit is latched at slot start so an and seg always move together.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
      r_an        <= 4'hF;
      r_seg       <= SEG_BLANK;
    end else if (w_scan_wrap) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
      r_an        <= ~(4'b0001 << r_digit_idx);
      r_seg       <= w_seg_dec;
    end else begin
      r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
    end
  end

`ifdef GAMEOVER_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blank;
  logic               w_gate;

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (w_go_entry) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (w_state_nxt == S_HOLD) begin
      if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blank     <= !r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign w_gate = (r_state == S_HOLD) && r_blank;
  assign an     = w_gate ? 4'hF : r_an;
  assign seg    = w_gate ? SEG_BLANK : r_seg;
`else
  assign an  = r_an;
  assign seg = r_seg;
`endif

  assign score_bcd  = r_score;
  assign high_bcd   = r_high;
  assign new_record = r_new_record;

endmodule

// File: tb/tb_score_display_keeper.sv
// Scoreboard bench: an integer-level model queues the expected outputs per edge, a monitor pops and compares.
module tb_score_display_keeper;

  localparam int SEC_DIV = 10, SCAN_DIV = 4, DP = 3, BLINK_DIV = 8;

  logic        clk_25MHz = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  current_state = 2'b00;
  logic        GEN_X = 1'b0;
  logic [15:0] score_bcd, high_bcd;
  logic        new_record;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk_25MHz = ~clk_25MHz;

  score_display_keeper #(
    .SEC_DIV(SEC_DIV), .SCAN_DIV(SCAN_DIV), .DODGE_POINTS(DP), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .current_state(current_state), .GEN_X(GEN_X),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .new_record(new_record), .seg(seg), .an(an)
  );

  typedef struct packed {
    logic [15:0] score;
    logic [15:0] high;
    logic        nr;
    logic [7:0]  seg;
    logic [3:0]  an;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         pow10 [4] = '{1, 10, 100, 1000};

  // Model state: plain integers; mode 0 idle, 1 run, 2 hold.
  int         m_prev, m_sec, m_score, m_high, m_mode_reg, m_scan, m_idx, m_blink_cnt;
  bit         m_gen_d, m_nr, m_blank;
  logic [7:0] m_seg;
  logic [3:0] m_an;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_sec = 0; m_score = 0; m_high = 0; m_mode_reg = 0;
    m_scan = 0; m_idx = 0; m_blink_cnt = 0; m_gen_d = 0; m_nr = 0; m_blank = 0;
    m_seg = 8'hFF; m_an = 4'hF;
  endtask

  task automatic model_step(input bit rst, input int cs, input bit g);
    int  mode, add, shown, n_score, n_sec;
    bit  run_entry, go_entry, tick;
    if (rst) begin
      model_reset();
      return;
    end
    mode      = (cs == 0) ? 0 : (cs == 3) ? 2 : 1;
    run_entry = (m_prev == 0) && (cs == 1);
    go_entry  = (m_prev != 3) && (cs == 3);
    n_score   = m_score;
    n_sec     = m_sec;
    if (mode == 1) begin
      if (run_entry) begin
        n_score = 0;
        n_sec   = 0;
      end else begin
        tick    = (m_sec == SEC_DIV - 1);
        n_sec   = tick ? 0 : m_sec + 1;
        add     = (tick ? 1 : 0) + ((g && !m_gen_d) ? DP : 0);
        n_score = (m_score + add > 9999) ? 9999 : m_score + add;
      end
    end
    m_nr = go_entry && (m_score > m_high);
    if (m_nr) m_high = m_score;
    if (m_scan == SCAN_DIV - 1) begin
      m_scan = 0;
      shown  = (m_mode_reg == 0) ? m_high : m_score;
      m_seg  = seg_tbl[shown / pow10[m_idx] % 10];
      m_an   = 4'hF;
      m_an[m_idx] = 1'b0;
      m_idx  = (m_idx + 1) % 4;
    end else begin
      m_scan++;
    end
    if (go_entry) begin
      m_blink_cnt = 0;
      m_blank     = 0;
    end else if (mode == 2) begin
      if (m_blink_cnt == BLINK_DIV - 1) begin
        m_blink_cnt = 0;
        m_blank     = !m_blank;
      end else begin
        m_blink_cnt++;
      end
    end
    m_score    = n_score;
    m_sec      = n_sec;
    m_mode_reg = mode;
    m_prev     = cs;
    m_gen_d    = g;
  endtask

  function automatic exp_t model_out();
    exp_t o;
    o.score = to_bcd(m_score);
    o.high  = to_bcd(m_high);
    o.nr    = m_nr;
    o.seg   = m_seg;
    o.an    = m_an;
`ifdef GAMEOVER_BLINK_EN
    if (m_mode_reg == 2 && m_blank) begin
      o.an  = 4'hF;
      o.seg = 8'hFF;
    end
`endif
    return o;
  endfunction

  task automatic step(input bit rst, input int cs, input bit g);
    @(negedge clk_25MHz);
    reset         = rst;
    current_state = 2'(cs);
    GEN_X         = g;
    model_step(rst, cs, g);
    exp_q.push_back(model_out());
  endtask

  // Returns just after the edge that consumed the last step.
  task automatic wait_edge();
    @(posedge clk_25MHz);
    #2;
  endtask

  always @(posedge clk_25MHz) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("mon_score", 32'(score_bcd), 32'(mon_e.score));
      chk("mon_high", 32'(high_bcd), 32'(mon_e.high));
      chk("mon_new_record", 32'(new_record), 32'(mon_e.nr));
      chk("mon_seg", 32'(seg), 32'(mon_e.seg));
      chk("mon_an", 32'(an), 32'(mon_e.an));
    end
  end

  task automatic run_dodges(input int n, input int extra);
    step(0, 1, 0);
    repeat (n) begin
      step(0, 1, 1);
      step(0, 1, 0);
    end
    repeat (extra) step(0, 1, 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_score"}, 32'(score_bcd), 32'h0);
    chk({tag, "_high"}, 32'(high_bcd), 32'h0);
    chk({tag, "_new_record"}, 32'(new_record), 32'h0);
    chk({tag, "_seg"}, 32'(seg), 32'hFF);
    chk({tag, "_an"}, 32'(an), 32'hF);
  endtask

  task automatic game_over_check(input string tag, input logic nr_req, input logic [15:0] high_req);
    step(0, 3, 0);
    wait_edge();
    chk({tag, "_pulse"}, 32'(new_record), 32'(nr_req));
    chk({tag, "_high"}, 32'(high_bcd), 32'(high_req));
    step(0, 3, 0);
    wait_edge();
    chk({tag, "_pulse_end"}, 32'(new_record), 32'h0);
    step(0, 0, 0);
  endtask

  initial begin
    int base, guard, cs;
    model_reset();

    repeat (3) step(1, 0, 0);
    wait_edge();
    chk_reset_values("reset");

    repeat (2) step(0, 0, 0);
    repeat (35) step(0, 1, 0);
    wait_edge();
    chk("run_score_3", 32'(score_bcd), 32'h0003);

    while (m_sec != 0) step(0, 1, 0);
    base = m_score;
    repeat (6) step(0, 1, 1);
    step(0, 1, 0);
    wait_edge();
    chk("dodge_plus3", 32'(score_bcd), 32'(to_bcd(base + 3)));

    while (m_sec != SEC_DIV - 1) step(0, 2, 0);
    base = m_score;
    step(0, 2, 1);
    wait_edge();
    chk("tick_dodge_plus4", 32'(score_bcd), 32'(to_bcd(base + 4)));

    step(0, 3, 0);
    repeat (2) step(0, 0, 0);
    run_dodges(9, 0);
    wait_edge();
    chk("carry_0028", 32'(score_bcd), 32'h0028);
    step(0, 3, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    run_dodges(4, 0);
    wait_edge();
    chk("hs_run1_score", 32'(score_bcd), 32'h0012);
    game_over_check("hs_first", 1'b1, 16'h0012);
    run_dodges(4, 0);
    game_over_check("hs_equal", 1'b0, 16'h0012);
    run_dodges(4, 2);
    wait_edge();
    chk("hs_run3_score", 32'(score_bcd), 32'h0013);
    game_over_check("hs_beat", 1'b1, 16'h0013);

    run_dodges(2, 6);
    wait_edge();
    chk("midrun_score_7", 32'(score_bcd), 32'h0007);
    step(1, 1, 0);
    wait_edge();
    chk_reset_values("midrun_reset");

    cs = 1;
    repeat (800) begin
      if ($urandom_range(15) == 0) cs = int'($urandom_range(3));
      step($urandom_range(299) == 0, cs, 1'($urandom_range(1)));
    end

    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    guard = 0;
    while (m_score < 9999 && guard < 20000) begin
      step(0, 1, 1);
      step(0, 1, 0);
      guard++;
    end
    chk("sat_reach_bound", 32'(guard < 20000), 32'h1);
    repeat (20) step(0, 1, 1'($urandom_range(1)));
    wait_edge();
    chk("sat_9999", 32'(score_bcd), 32'h9999);
    game_over_check("sat_record", 1'b1, 16'h9999);
    repeat (4) step(0, 0, 0);
    wait_edge();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
